// File: rtl/vga_trace_display_if.sv
// Column-sample handshake between the sample producer and vga_trace_display.
// Channel c occupies sample_y[c*Y_W +: Y_W].
interface vga_trace_display_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned Y_W      = 10
);
    logic                    sample_valid;
    logic                    sample_ready;
    logic [CHANNELS*Y_W-1:0] sample_y;

    modport master (
        output sample_valid,
        output sample_y,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_y,
        output sample_ready
    );
endinterface

// File: rtl/vga_trace_display.sv
// VGA raster engine with a scrolling multi-channel trace memory and 2-stage pixel pipeline.
// Define DISPLAY_GRID_EN to draw a background grid of GRID_COLOR every GRID_SPACING pixels.
module vga_trace_display #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned Y_W       = 10,
    parameter int unsigned RGB_W     = 3,
    parameter bit          SYNC_POL  = 1'b0,
    parameter logic [CHANNELS*RGB_W-1:0] CH_COLORS   = {3'b110, 3'b111},
    parameter logic [4*RGB_W-1:0]        MOOD_COLORS = {3'b000, 3'b100, 3'b010, 3'b001},
    parameter int unsigned GRID_SPACING = 32,
    parameter logic [RGB_W-1:0] GRID_COLOR = 3'b011
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mood,
    vga_trace_display_if.slave   smp,
    output logic                 hsync,
    output logic                 vsync,
    output logic [RGB_W-1:0]     rgb,
    output logic [$clog2(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0] x,
    output logic [$clog2(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0] y,
    output logic                 frame_start
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = $clog2(H_VISIBLE);
    localparam int unsigned HS_BEG  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END  = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned VS_BEG  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END  = V_VISIBLE + V_FRONT + V_SYNC;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    // ---------------------------------------------------------------- stage 0: raster counters
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;

    always_comb begin
        h_nxt = h_cnt + 1'b1;
        v_nxt = v_cnt;
        if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_nxt = '0;
            v_nxt = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // ---------------------------------------------------------------- clear/run FSM
    state_e        state;
    logic [CW-1:0] wr_col, col_inc;
    logic          ready;
    logic          accept;
    logic          nxt_blank;

    assign smp.sample_ready = ready;
    assign accept    = smp.sample_valid && ready;
    assign col_inc   = (wr_col == CW'(H_VISIBLE - 1)) ? '0 : wr_col + 1'b1;
    assign nxt_blank = 32'(v_nxt) >= V_VISIBLE;

    // ready is registered from next-state counter values so it tracks v_cnt >= V_VISIBLE exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StClear;
            wr_col <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                StClear: begin
                    wr_col <= col_inc;
                    ready  <= 1'b0;
                    if (wr_col == CW'(H_VISIBLE - 1)) begin
                        state <= StRun;
                        ready <= nxt_blank;
                    end
                end
                StRun: begin
                    if (accept) begin
                        wr_col <= col_inc;
                    end
                    ready <= nxt_blank;
                end
                default: begin
                    state <= StClear;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- trace memory
    logic [Y_W-1:0] mem [CHANNELS][H_VISIBLE];
    logic           mem_we;

    assign mem_we = !reset && ((state == StClear) || accept);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                mem[c][wr_col] <= (state == StClear) ? Y_W'(V_VISIBLE)
                                                     : smp.sample_y[c*Y_W +: Y_W];
            end
        end
    end

    // Oldest sample sits at x=0: screen column x maps to (wr_col + x) mod H_VISIBLE.
    logic [CW:0]   rd_sum;
    logic [CW-1:0] rd_addr;

    assign rd_sum  = {1'b0, wr_col} + {1'b0, h_cnt[CW-1:0]};
    assign rd_addr = (32'(rd_sum) >= H_VISIBLE) ? CW'(32'(rd_sum) - H_VISIBLE) : rd_sum[CW-1:0];

    // ---------------------------------------------------------------- stage 1: read + delay
    logic [HW-1:0]  s1_h;
    logic [VW-1:0]  s1_v;
    logic           s1_vis, s1_hs, s1_vs, s1_first, s1_run;
    logic [1:0]     s1_mood;
    logic [Y_W-1:0] s1_y [CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_h     <= '0;
            s1_v     <= '0;
            s1_vis   <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_first <= 1'b0;
            s1_run   <= 1'b0;
            s1_mood  <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                s1_y[c] <= '0;
            end
        end else begin
            s1_h     <= h_cnt;
            s1_v     <= v_cnt;
            s1_vis   <= (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
            s1_hs    <= (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
            s1_vs    <= (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);
            s1_first <= (h_cnt == '0) && (v_cnt == '0);
            s1_run   <= (state == StRun);
            s1_mood  <= mood;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                s1_y[c] <= mem[c][rd_addr];
            end
        end
    end

    // ---------------------------------------------------------------- stage 2: compare + colour
`ifdef DISPLAY_GRID_EN
    logic grid_on;
    assign grid_on = ((32'(s1_h) % GRID_SPACING) == 0) || ((32'(s1_v) % GRID_SPACING) == 0);
`else
    logic unused_grid;
    assign unused_grid = ^{GRID_COLOR, 32'(GRID_SPACING)};
`endif

    logic [RGB_W-1:0] pix;

    // Entries are only trusted once CLEAR has swept the whole memory.
    always_comb begin
        pix = MOOD_COLORS[s1_mood*RGB_W +: RGB_W];
`ifdef DISPLAY_GRID_EN
        if (grid_on) begin
            pix = GRID_COLOR;
        end
`endif
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (s1_run && (32'(s1_y[c]) == 32'(s1_v)) && (32'(s1_y[c]) < V_VISIBLE)) begin
                pix = CH_COLORS[c*RGB_W +: RGB_W];
            end
        end
        if (!s1_vis) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb         <= '0;
            x           <= '0;
            y           <= '0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            rgb         <= pix;
            x           <= s1_h;
            y           <= s1_v;
            hsync       <= s1_hs ? SYNC_POL : !SYNC_POL;
            vsync       <= s1_vs ? SYNC_POL : !SYNC_POL;
            frame_start <= s1_first;
        end
    end
endmodule

// File: tb/tb_vga_trace_display.sv
// Scoreboard bench for vga_trace_display on a reduced 16x12 raster (24x17 total).
// Expected pixels are queued in raster order; a monitor compares when the DUT reaches them.
module tb_vga_trace_display;
    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        int         px;
        int         py;
        logic [2:0] c;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  mood;
    logic        hsync, vsync, frame_start;
    logic [2:0]  rgb;
    logic [4:0]  x, y;
    int          checks = 0;
    int          failures = 0;
    int          cur_mood = 1;
    exp_t        exp_q[$];

    vga_trace_display_if #(.CHANNELS(2), .Y_W(10)) smp_if ();

    vga_trace_display #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .GRID_SPACING(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mood(mood),
        .smp(smp_if),
        .hsync(hsync),
        .vsync(vsync),
        .rgb(rgb),
        .x(x),
        .y(y),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [2:0] bg(input int xx, input int yy);
`ifdef DISPLAY_GRID_EN
        if ((xx % 4 == 0) || (yy % 4 == 0)) return 3'b011;
`endif
        case (cur_mood)
            0: return 3'b001;
            1: return 3'b010;
            2: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Monitor: compare the head expectation when the DUT presents that pixel.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            if (int'(x) == exp_q[0].px && int'(y) == exp_q[0].py) begin
                chk($sformatf("pix_%0d_%0d", exp_q[0].px, exp_q[0].py), int'(rgb),
                    int'(exp_q[0].c));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic exp_px(input int px, input int py, input logic [2:0] c);
        exp_q.push_back('{px, py, c});
    endtask

    task automatic exp_bg_frame();
        for (int yy = 0; yy < VV; yy++)
            for (int xx = 0; xx < HV; xx++)
                exp_px(xx, yy, bg(xx, yy));
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_leftover", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_ready();
        int seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (smp_if.sample_ready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_seen", seen, 1);
    endtask

    task automatic push_sample(input int v0, input int v1);
        int done = 0;
        smp_if.sample_y     = {10'(v1), 10'(v0)};
        smp_if.sample_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (smp_if.sample_ready) begin
                @(posedge clk);
                done = 1;
                break;
            end
            @(negedge clk);
        end
        chk("push_accept", done, 1);
        @(negedge clk);
        smp_if.sample_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rgb"}, int'(rgb), 0);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_ready"}, int'(smp_if.sample_ready), 0);
    endtask

    // Release reset, then watch CLEAR and one full frame of outputs starting at frame_start.
    task automatic release_and_measure(input string tag);
        int ready_hi = 0, hs_lo = 0, vs_lo = 0, fs_n = 0;
        int hs_bad = 0, vs_bad = 0, fs_bad = 0, out_bad = 0, bg_bad = 0;
        int xi, yi;
        reset = 1'b0;
        for (int n = 1; n <= FRAME + 1; n++) begin
            @(negedge clk);
            if (n <= HV && smp_if.sample_ready) ready_hi++;
            if (n == 1) chk({tag, "_fs_early"}, int'(frame_start), 0);
            if (n == 2) chk({tag, "_fs_latency"}, int'(frame_start), 1);
            if (n >= 2) begin
                xi = int'(x);
                yi = int'(y);
                if (!hsync) hs_lo++;
                if (!vsync) vs_lo++;
                if (frame_start) fs_n++;
                if ((xi >= HV + HF && xi < HV + HF + HS) != !hsync) hs_bad++;
                if ((yi >= VV + VF && yi < VV + VF + VS) != !vsync) vs_bad++;
                if (frame_start && (xi != 0 || yi != 0)) fs_bad++;
                if (xi >= HV || yi >= VV) begin
                    if (rgb != 3'b000) out_bad++;
                end else if (rgb != bg(xi, yi)) begin
                    bg_bad++;
                end
            end
        end
        chk({tag, "_ready_in_clear"}, ready_hi, 0);
        chk({tag, "_hsync_low_cycles"}, hs_lo, 51);
        chk({tag, "_vsync_low_cycles"}, vs_lo, 48);
        chk({tag, "_frame_starts"}, fs_n, 1);
        chk({tag, "_hsync_vs_x"}, hs_bad, 0);
        chk({tag, "_vsync_vs_y"}, vs_bad, 0);
        chk({tag, "_fs_at_origin"}, fs_bad, 0);
        chk({tag, "_blank_rgb"}, out_bad, 0);
        chk({tag, "_background"}, bg_bad, 0);
    endtask

    initial begin
        int found;
        reset               = 1'b1;
        mood                = 2'b01;
        cur_mood            = 1;
        smp_if.sample_valid = 1'b0;
        smp_if.sample_y     = '0;
        repeat (4) @(negedge clk);
        check_reset_vals("por");
        release_and_measure("por");

        // Empty memory: whole visible area is background.
        wait_ready();
        exp_bg_frame();
        drain();

        // Three samples: newest lands at the right edge.
        wait_ready();
        repeat (3) push_sample(3, 7);
        exp_px(12, 3, bg(12, 3));
        exp_px(13, 3, 3'b111);
        exp_px(14, 3, 3'b111);
        exp_px(15, 3, 3'b111);
        exp_px(20, 3, 3'b000);
        exp_px(12, 7, bg(12, 7));
        exp_px(13, 7, 3'b110);
        exp_px(14, 7, 3'b110);
        exp_px(15, 7, 3'b110);
        drain();

        // Both channels on the same row: channel 0 wins; mood switched to 2.
        wait_ready();
        mood     = 2'b10;
        cur_mood = 2;
        push_sample(5, 5);
        exp_px(11, 3, bg(11, 3));
        exp_px(12, 3, 3'b111);
        exp_px(14, 3, 3'b111);
        exp_px(15, 5, 3'b111);
        exp_px(13, 7, 3'b110);
        drain();

        // 17 samples in total: write pointer wraps to column 1.
        wait_ready();
        mood     = 2'b01;
        cur_mood = 1;
        repeat (12) push_sample(11, 12);
        push_sample(9, 12);
        exp_px(0, 3, 3'b111);
        exp_px(2, 5, 3'b111);
        exp_px(0, 7, 3'b110);
        exp_px(15, 9, 3'b111);
        exp_px(14, 11, 3'b111);
        exp_px(15, 11, bg(15, 11));
        drain();

        // Reset mid-line: CLEAR reruns and every trace disappears.
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (int'(x) == 5 && int'(y) == 3) begin
                found = 1;
                break;
            end
        end
        chk("midline_found", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid");
        repeat (2) @(negedge clk);
        release_and_measure("mid");
        wait_ready();
        exp_bg_frame();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(FRAME * 40 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
